// File: rtl/zcache_nway.sv
// -----------------------------------------------------------------------------
// zcache_nway
//   N-way set-associative read cache on the Z80 -> DRAM memory path.
//   Z80 reads look up all ways at the addressed set. DRAM read strobes fill the
//   set, using round-robin replacement. Z80 writes invalidate matching lines.
//   A sequential flush engine clears one set per cycle, after a flush request
//   and after reset.
//
// Ports
//   clk, rst    system clock; synchronous active-high reset
//   addr        DRAM word address {page, za[13:1]}: index = low IDXW bits
//   win         Z80 window za[15:14]; win_en[win] gates hit
//   rd          Z80 memory read in progress (RAM target)
//   wr_s        single-cycle Z80 RAM write strobe -> invalidate
//   fill        DRAM read strobe, fill_data valid -> allocate/update line
//   flush       single-cycle request to invalidate the whole cache
//   hit, rdata  registered lookup result, one cycle after addr/rd
//   busy        flush engine active; lookups miss, fill/wr_s ignored
// -----------------------------------------------------------------------------
module zcache_nway #(
  parameter int WAYS = 2,
  parameter int IDXW = 8,
  parameter int AW   = 21,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    win,
  input  logic [3:0]    win_en,
  input  logic          rd,
  input  logic          wr_s,
  input  logic          fill,
  input  logic [DW-1:0] fill_data,
  input  logic          flush,
  output logic          hit,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  localparam int SETS = 1 << IDXW;
  localparam int TW   = AW - IDXW;
  // Way-select / victim width; kept at 1 bit for WAYS=1 and held at zero.
  localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t          state;
  logic [IDXW-1:0] fidx;

  // Tag entry layout: {valid, tag}.
  logic [TW:0]     tag_mem  [WAYS][SETS];
  logic [DW-1:0]   data_mem [WAYS][SETS];
  logic [VW-1:0]   vic_mem  [SETS];

  logic [IDXW-1:0] idx;
  logic [TW-1:0]   tag;
  logic [WAYS-1:0] way_hit;
  logic [WAYS-1:0] way_inv;
  logic [DW-1:0]   hit_data;
  logic [VW-1:0]   hit_way;
  logic [VW-1:0]   inv_way;
  logic [VW-1:0]   vic;
  logic [VW-1:0]   vic_next;
  logic [VW-1:0]   fill_way;
  logic            upd_vic;
  logic            fill_go;
  logic            inval_go;

  assign idx  = addr[IDXW-1:0];
  assign tag  = addr[AW-1:IDXW];
  assign busy = (state == S_FLUSH);

  // Writes are blocked during flush and while reset is held.
  assign fill_go  = fill && !busy && !rst;
  assign inval_go = wr_s && !busy && !rst;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    way_hit  = '0;
    way_inv  = '0;
    hit_data = '0;
    hit_way  = '0;
    inv_way  = '0;
    for (int k = 0; k < WAYS; k++) begin
      way_hit[k] = tag_mem[k][idx][TW] && (tag_mem[k][idx][TW-1:0] == tag);
      way_inv[k] = !tag_mem[k][idx][TW];
    end
    // Descending scan so the lowest-numbered matching way wins.
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (way_hit[k]) begin
        hit_data = data_mem[k][idx];
        hit_way  = VW'(k);
      end
      if (way_inv[k]) inv_way = VW'(k);
    end
  end

  // Replacement choice: hitting way, else first invalid way, else victim.
  always_comb begin
    vic      = vic_mem[idx];
    vic_next = vic + VW'(1);
    if (WAYS == 1) vic_next = '0;
    fill_way = vic;
    upd_vic  = 1'b1;
    if (|way_hit) begin
      fill_way = hit_way;
      upd_vic  = 1'b0;
    end else if (|way_inv) begin
      fill_way = inv_way;
      upd_vic  = 1'b0;
    end
  end

  // NOTE: the RAM arrays have no reset term; the flush engine clears valid
  // bits and victim pointers, and data contents are never observed unless valid.
  always_ff @(posedge clk) begin
    if (busy) begin
      for (int k = 0; k < WAYS; k++) tag_mem[k][fidx] <= '0;
      vic_mem[fidx] <= '0;
    end else begin
      for (int k = 0; k < WAYS; k++) begin
        if (fill_go && (fill_way == VW'(k))) begin
          // A same-cycle write strobe leaves the freshly filled line invalid.
          tag_mem[k][idx]  <= {!inval_go, tag};
          data_mem[k][idx] <= fill_data;
        end else if (inval_go && way_hit[k]) begin
          tag_mem[k][idx][TW] <= 1'b0;
        end
      end
      if (fill_go && upd_vic) vic_mem[idx] <= vic_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FLUSH;
      fidx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            state <= S_FLUSH;
            fidx  <= '0;
          end
        end
        S_FLUSH: begin
          fidx <= fidx + IDXW'(1);
          if (&fidx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered lookup result: one-cycle latency, old RAM state on same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit   <= 1'b0;
      rdata <= '0;
    end else begin
      hit   <= rd && win_en[win] && !busy && (|way_hit);
      rdata <= (!busy && (|way_hit)) ? hit_data : '0;
    end
  end

endmodule

// File: tb/tb_zcache_nway.sv
// -----------------------------------------------------------------------------
// tb_zcache_nway
//   Directed bench for zcache_nway. Three instances (WAYS = 2, 1, 4) share
//   the same stimulus. The 2-way instance is the main device; the 1-way and
//   4-way instances are compared on the replacement sequence.
// -----------------------------------------------------------------------------
module tb_zcache_nway;

  localparam int AW   = 21;
  localparam int DW   = 16;
  localparam int SETS = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [1:0]    win;
  logic [3:0]    win_en;
  logic          rd, wr_s, fill, flush;
  logic [DW-1:0] fill_data;

  logic          hit2, hit1, hit4, busy2, busy1, busy4;
  logic [DW-1:0] rdata2, rdata1, rdata4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zcache_nway #(.WAYS(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .win(win), .win_en(win_en), .rd(rd),
    .wr_s(wr_s), .fill(fill), .fill_data(fill_data), .flush(flush),
    .hit(hit2), .rdata(rdata2), .busy(busy2));

  zcache_nway #(.WAYS(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr), .win(win), .win_en(win_en), .rd(rd),
    .wr_s(wr_s), .fill(fill), .fill_data(fill_data), .flush(flush),
    .hit(hit1), .rdata(rdata1), .busy(busy1));

  zcache_nway #(.WAYS(4)) dut4 (
    .clk(clk), .rst(rst), .addr(addr), .win(win), .win_en(win_en), .rd(rd),
    .wr_s(wr_s), .fill(fill), .fill_data(fill_data), .flush(flush),
    .hit(hit4), .rdata(rdata4), .busy(busy4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; samples and new drives happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; fill_data = d; fill = 1'b1;
    tick();
    fill = 1'b0;
  endtask

  task automatic do_inval(input logic [AW-1:0] a);
    addr = a; wr_s = 1'b1;
    tick();
    wr_s = 1'b0;
  endtask

  // Present a lookup for one cycle; outputs are valid on return.
  task automatic lookup(input logic [AW-1:0] a, input logic [1:0] w, input logic [3:0] en);
    addr = a; win = w; win_en = en; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          is_fill;
    logic [DW-1:0] data;
    logic          hit2;
    logic [DW-1:0] rdata2;
    logic          hit1;
    logic          hit4;
  } vec_t;

  // Conflict set 0x45; tags A..E = 0x0A1, 0x0B2, 0x0C3, 0x0D4, 0x0E5.
  localparam logic [AW-1:0] A_ADR = 21'h00A145;
  localparam logic [AW-1:0] B_ADR = 21'h00B245;
  localparam logic [AW-1:0] C_ADR = 21'h00C345;
  localparam logic [AW-1:0] D_ADR = 21'h00D445;
  localparam logic [AW-1:0] E_ADR = 21'h00E545;

  vec_t vecs[15];
  int   n;
  logic seen_hit;

  initial begin
    rst = 1'b1; addr = '0; win = '0; win_en = 4'hF; rd = 1'b0;
    wr_s = 1'b0; fill = 1'b0; flush = 1'b0; fill_data = '0;

    // Replacement table: fills and lookups with per-build expectations.
    vecs[0]  = '{A_ADR, 1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{B_ADR, 1'b1, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{C_ADR, 1'b1, 16'h3333, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{A_ADR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{B_ADR, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b1};
    vecs[5]  = '{C_ADR, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 1'b1};
    vecs[6]  = '{D_ADR, 1'b1, 16'h4444, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{B_ADR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{C_ADR, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b0, 1'b1};
    vecs[9]  = '{D_ADR, 1'b0, 16'h0000, 1'b1, 16'h4444, 1'b1, 1'b1};
    vecs[10] = '{E_ADR, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{A_ADR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[12] = '{C_ADR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[13] = '{D_ADR, 1'b0, 16'h0000, 1'b1, 16'h4444, 1'b0, 1'b1};
    vecs[14] = '{E_ADR, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b1, 1'b1};

    // ---- Reset: busy for exactly SETS cycles after release, lookups miss ----
    tick(); tick();
    check("busy_in_reset", busy2, 1'b1);
    check("hit_in_reset", hit2, 1'b0);
    check("rdata_in_reset", rdata2, 16'h0);
    rst = 1'b0;
    addr = 21'h012345; rd = 1'b1; win_en = 4'hF;
    n = 0; seen_hit = 1'b0;
    while (busy2 && n < 1000) begin
      tick();
      n++;
      if (hit2 || hit1 || hit4) seen_hit = 1'b1;
    end
    rd = 1'b0;
    check("reset_busy_cycles", n, SETS);
    check("hit_during_reset_flush", seen_hit, 1'b0);
    check("busy1_done", busy1, 1'b0);
    check("busy4_done", busy4, 1'b0);

    // ---- Fill then hit, with window enable qualification ----
    do_fill(21'h012345, 16'hBEEF);
    lookup(21'h012345, 2'd0, 4'b1111);
    check("fill_hit", hit2, 1'b1);
    check("fill_rdata", rdata2, 16'hBEEF);
    lookup(21'h012345, 2'd2, 4'b1011);
    check("win_disabled_hit", hit2, 1'b0);

    // Lookup in the same cycle as its fill sees old state; next lookup hits.
    addr = 21'h000077; fill_data = 16'h7777; fill = 1'b1; rd = 1'b1; win = 2'd0;
    tick();
    fill = 1'b0;
    check("same_cycle_fill_old_state", hit2, 1'b0);
    tick();
    rd = 1'b0;
    check("next_cycle_fill_new_state", hit2, 1'b1);
    check("next_cycle_fill_rdata", rdata2, 16'h7777);

    // ---- Write invalidation ----
    do_fill(21'h000010, 16'hCAFE);
    lookup(21'h000010, 2'd1, 4'hF);
    check("inval_pre_hit", hit2, 1'b1);
    do_inval(21'h000010);
    lookup(21'h000010, 2'd1, 4'hF);
    check("inval_hit", hit2, 1'b0);
    // Simultaneous fill + write on a missing line.
    addr = 21'h000010; fill_data = 16'h1234; fill = 1'b1; wr_s = 1'b1;
    tick();
    fill = 1'b0; wr_s = 1'b0;
    lookup(21'h000010, 2'd1, 4'hF);
    check("fill_wr_miss_line", hit2, 1'b0);
    // Simultaneous fill + write on a resident line.
    do_fill(21'h000020, 16'hDEAD);
    addr = 21'h000020; fill_data = 16'hD00D; fill = 1'b1; wr_s = 1'b1;
    tick();
    fill = 1'b0; wr_s = 1'b0;
    lookup(21'h000020, 2'd1, 4'hF);
    check("fill_wr_hit_line", hit2, 1'b0);

    // ---- Flush mid-operation, second pulse ignored ----
    do_fill(21'h000101, 16'h0101);
    do_fill(21'h000202, 16'h0202);
    do_fill(21'h000303, 16'h0303);
    lookup(21'h000303, 2'd0, 4'hF);
    check("preflush_hit", hit2, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_rise", busy2, 1'b1);
    n = 0;
    while (busy2 && n < 1000) begin
      if (n == 10) flush = 1'b1;
      tick();
      flush = 1'b0;
      n++;
    end
    check("flush_busy_cycles", n, SETS);
    lookup(21'h000101, 2'd0, 4'hF); check("post_flush_miss_101", hit2, 1'b0);
    lookup(21'h000202, 2'd0, 4'hF); check("post_flush_miss_202", hit2, 1'b0);
    lookup(21'h000303, 2'd0, 4'hF); check("post_flush_miss_303", hit2, 1'b0);
    lookup(21'h012345, 2'd0, 4'hF); check("post_flush_miss_12345", hit2, 1'b0);
    lookup(21'h000077, 2'd0, 4'hF); check("post_flush_miss_77", hit2, 1'b0);

    // ---- Reset at flush index 100 restarts the sweep ----
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("busy_before_rst", busy2, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("busy_after_mid_rst", busy2, 1'b1);
    n = 0;
    while (busy2 && n < 1000) begin
      tick();
      n++;
    end
    check("rst_restart_busy_cycles", n, SETS);

    // ---- Replacement table across WAYS = 2, 1, 4 ----
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_fill) begin
        do_fill(vecs[i].addr, vecs[i].data);
      end else begin
        lookup(vecs[i].addr, 2'd3, 4'b1000);
        check($sformatf("vec%0d_hit2", i), hit2, vecs[i].hit2);
        check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].rdata2);
        check($sformatf("vec%0d_hit1", i), hit1, vecs[i].hit1);
        check($sformatf("vec%0d_hit4", i), hit4, vecs[i].hit4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zcache_nway.md
# zcache_nway

Parametrised N-way set-associative read cache for the Z80 memory path. It sits between the Z80 memory manager and the DRAM arbiter, in place of the direct-mapped 256-word cache. It adds configurable ways, depth and address width, round-robin replacement, and a sequential flush engine that also clears all valid bits after reset. It serves 16-bit DRAM words to Z80 reads, fills from DRAM read strobes, and invalidates on Z80 writes.

## Interface
Parameters:
- WAYS, 2, number of ways; legal values 1, 2, 4.
- IDXW, 8, set index width; SETS = 2^IDXW.
- AW, 21, DRAM word address width; tag width TW = AW-IDXW.
- DW, 16, data word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- addr  in  AW  word address {page, za[13:1]}; index = addr[IDXW-1:0], tag = addr[AW-1:IDXW].
- win  in  2  Z80 window za[15:14] of the current access.
- win_en  in  4  per-window cache enable.
- rd  in  1  Z80 memory read in progress; RAM target.
- wr_s  in  1  single-cycle Z80 RAM write strobe, write enabled.
- fill  in  1  DRAM read data strobe; fill_data valid.
- fill_data  in  DW  DRAM read word.
- flush  in  1  single-cycle request to invalidate the whole cache.
- hit  out  1  lookup hit, qualified by rd, win_en[win] and !busy.
- rdata  out  DW  cached word of the hitting way.
- busy  out  1  flush engine active.

## Operation
- Storage: per way, a data RAM of SETS×DW and a tag RAM of SETS×(1+TW) holding {valid, tag}. Per set, a victim pointer of log2(WAYS) bits, zero width when WAYS=1.
- Lookup: all ways are read at addr's index every cycle. way_hit[k] = valid[k] && tag[k]==addr tag. hit = rd && win_en[win] && !busy && |way_hit. rdata comes from the lowest-numbered hitting way, else 0.
- Fill, when fill && !busy: the target way is chosen in this order:
  - the hitting way, if any; victim pointer unchanged;
  - else the lowest-numbered invalid way; victim pointer unchanged;
  - else the way at the victim pointer; pointer increments modulo WAYS.
  - The selected way is written with {1, tag} and fill_data.
- Invalidate, when wr_s && !busy: every hitting way in the set gets valid=0. Data is untouched. Victim pointer is unchanged.
- fill and wr_s in the same cycle for the same set: invalidate wins, and the written way ends with valid=0.
- Flush FSM states:
  - IDLE → FLUSH on flush or on rst.
  - FLUSH: index counter runs 0..SETS-1, one set per cycle. Each step writes valid=0 in all ways and victim=0.
  - FLUSH → IDLE after index SETS-1.
  - flush while in FLUSH is ignored. rst while in FLUSH restarts from index 0.
- While busy: hit=0, fill and wr_s are ignored. The Z80 memory manager must treat this as a miss and go to DRAM.

## Timing
- Reset values:
  - busy=1 from the first clock after rst is asserted until SETS cycles after rst deasserts.
  - hit=0, rdata=0 throughout.
- Lookup latency is 1 cycle. addr, win and rd presented at cycle t give hit and rdata valid in cycle t+1. The source holds addr stable for the whole Z80 access.
- Writes (fill, invalidate, flush step) presented at cycle t take effect in RAM at the edge ending t.
  - A lookup of the same address at t+1 returns the new state at t+2.
  - A lookup at t itself still returns the old state at t+1.
- Flush duration is exactly SETS cycles. busy rises in the cycle after the flush pulse and falls after SETS cycles.
- The victim pointer update and the fill write occur on the same edge.
- No output is combinational from fill or wr_s.

## Test plan
- Reset: pulse rst for 1 cycle, with IDXW=8. Required: busy=1 for 256 cycles after release, then 0. Any lookup during that window gives hit=0.
- Fill then hit: fill addr 0x012345 with data 0xBEEF. Then rd with addr 0x012345 and win_en=4'b1111. Required: at t+1 hit=1 and rdata=0xBEEF. Repeat with win_en[win]=0: hit=0.
- Conflict (WAYS=2): fill tags A, B, C into set 0x45, with data 0x1111, 0x2222, 0x3333.
  - Required: A is evicted, since the victim pointer was 0 and is now 1. B and C hit.
  - A fourth fill D evicts B.
- Write invalidation: fill 0x000010 with 0xCAFE, pulse wr_s at the same addr, then read. Required: hit=0. A fill and wr_s in the same cycle also leaves hit=0.
- Flush mid-operation: fill 4 distinct sets, pulse flush, pulse flush again 10 cycles later.
  - Required: busy lasts exactly SETS cycles, with the second pulse ignored. All 4 addresses miss afterwards.
  - rst at index 100 restarts the flush, so busy lasts SETS cycles after the rst.
- WAYS=1 and WAYS=4 builds: the same fill/hit/evict sequence behaves identically to a direct-mapped cache, resp. 4-deep round-robin.
